ram_dma_ci_engine: RTL and testbench
====================================

// Module: ram_dma_ci_engine
// PURPOSE
//  Custom-instruction (CI) scratchpad with an integrated bus-master DMA engine for the OpenRISC virtual prototype.
//  CPU side: read/write a dual-port SSRAM directly (bypass), or program DMA registers through the CI.
//  The DMA moves blocks between SSRAM port B and the shared bus in bursts, in either direction, and reports busy/error status.
// PARAMETERS
//  customId   8'h00  CI opcode this block answers to (ciN == customId)
//  ramDepth   512    SSRAM entries, 32-bit words; power of 2; ADDR_W = clog2(ramDepth)
//  maxBurst   16     largest burst in words; burst register is clamped to this value
// PORTS
//  clock                 in   1   system clock
//  reset                 in   1   asynchronous, active-high reset
//  start                 in   1   CI strobe
//  ciN                   in   8   CI opcode
//  valueA                in   32  [ADDR_W-1:0] SSRAM address; [9] 1=write; [12:10] select
//  valueB                in   32  write data
//  done                  out  1   CI complete, one-cycle pulse
//  result                out  32  CI read data, valid only while done=1, otherwise 0
//  requestTransaction    out  1   bus request
//  transactionGranted    in   1   bus grant
//  beginTransactionOut   out  1   address phase, one cycle
//  addressDataOut        out  32  address during begin; write data during data phase
//  burstSizeOut          out  8   burst length minus 1
//  readNotWriteOut       out  1   1 = bus read
//  byteEnablesOut        out  4   always 4'hF during begin, else 0
//  dataValidOut          out  1   write-data beat valid
//  endTransactionOut     out  1   last-cycle marker for master writes
//  busyIn                in   1   slave stall for write beats
//  dataValidIn           in   1   read beat valid
//  addressDataIn         in   32  read beat data
//  endTransactionIn      in   1   slave ends transaction
//  busErrorIn            in   1   bus error
// BEHAVIOUR
//  CI select valueA[12:10]: 000 SSRAM bypass; 001 busStartAddr; 010 memStartAddr; 011 blockSize (words, 10b);
//    100 burstSize (words-1, 8b); 101 control(write)/status(read); 110/111 reserved (done=1, result=0).
//  Bypass write: done in the start cycle. Bypass read: done one cycle after start; result = SSRAM word.
//  Register access: done in the start cycle; a read returns the register value.
//  Register writes while busy are ignored. All registers reset to 0.
//  Control write: valueB[0] starts bus->SSRAM; valueB[1] starts SSRAM->bus. Both set = bus->SSRAM.
//  A start while busy is ignored. A start clears the error bit.
//  Status read: {30'b0, error, busy}.
//  FSM: IDLE -> REQ (requestTransaction=1 until transactionGranted) -> BEGIN (1 cycle; address = current bus address, len = min(remaining, burst+1, maxBurst) - 1)
//    -> RD_DATA or WR_DATA -> NEXT -> REQ while remaining > 0, else IDLE.
//  RD_DATA: each dataValidIn writes addressDataIn to SSRAM port B at memAddr, then memAddr++.
//    The burst ends on endTransactionIn.
//  WR_DATA: SSRAM port B word is prefetched one cycle ahead. A beat advances only when busyIn=0.
//    endTransactionOut is asserted for one cycle after the last beat.
//  After each burst: busAddr += 4*len; remaining -= len. memAddr wraps modulo ramDepth.
//  Beats received beyond the programmed burst length are dropped.
//  blockSize == 0: a start sets no busy flag and causes no bus activity.
//  busErrorIn in any non-IDLE state: set error, release all bus outputs, go to IDLE.
//  Bypass and DMA share the SSRAM on separate ports. A same-address collision in the same cycle is undefined data but is not a deadlock.
//  Reset (also mid-transfer): FSM IDLE, all bus outputs 0, done=0, result=0, busy=0, error=0.
//  When not active, all bus outputs drive 0 (wired-OR bus).
// STRUCTURE
//  Package ram_dma_ci_pkg: select codes, FSM state encoding, status bit positions.
//  Sub-module dual_port_ssram (existing; bitwidth 32, nrOfEntries ramDepth), instantiated once.
//    Port A is driven by the CI; port B is driven by the DMA.
//  The rest stays in one module: CI decode, register file, DMA FSM, burst counter.
// TESTING
//  Bypass: write 0xDEADBEEF @5 -> done same cycle; read @5 -> done 1 cycle later, result 0xDEADBEEF.
//  Regs: write busStart=0x4000, block=20, burst=7; read back -> identical values; reserved select -> result 0.
//  Bus->SSRAM, block 20, burst 7, memStart 0 -> bursts of 8, 8, 4 at addresses 0x4000, 0x4020, 0x4040.
//    SSRAM[0..19] = bus data; status goes busy, then 0.
//  SSRAM->bus, block 5, burst 15, busyIn toggling -> 5 write beats in order, no beat lost or duplicated.
//    endTransactionOut asserted once.
//  busErrorIn during the 2nd burst -> status = 2'b10; bus outputs 0 the next cycle; a new start clears the error.
//  Reset mid-burst -> all outputs 0, status 0; memStart=ramDepth-2 with block 4 -> writes wrap to entries 0..1.

Source files
------------

// File: rtl/ram_dma_ci_pkg.sv
// rtl/ram_dma_ci_pkg.sv - shared encodings for the CI scratchpad DMA engine
// Purpose: CI select codes, control/status bit positions, register widths,
//          DMA FSM state encoding.
package ram_dma_ci_pkg;

    // valueA[12:10] register select
    localparam logic [2:0] SEL_BYPASS   = 3'd0;
    localparam logic [2:0] SEL_BUS_ADDR = 3'd1;
    localparam logic [2:0] SEL_MEM_ADDR = 3'd2;
    localparam logic [2:0] SEL_BLOCK    = 3'd3;
    localparam logic [2:0] SEL_BURST    = 3'd4;
    localparam logic [2:0] SEL_CTRL     = 3'd5;

    // control write bits
    localparam int CTRL_RD_BUS = 0;  // bus -> SSRAM
    localparam int CTRL_WR_BUS = 1;  // SSRAM -> bus

    // status read bits
    localparam int STAT_BUSY  = 0;
    localparam int STAT_ERROR = 1;

    localparam int BLOCK_W = 10;
    localparam int BURST_W = 8;
    localparam int LEN_W   = 9;      // burst length in words, up to 256

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_BEGIN,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_NEXT
    } dma_state_e;

endpackage

// File: rtl/dual_port_ssram.sv
// rtl/dual_port_ssram.sv - dual-port synchronous SRAM, read-old-data per port
// Ports: clock; per port A/B: address, writeEnable, dataIn, dataOut (registered read).
// A same-address write on both ports in one cycle leaves port B's data.
module dual_port_ssram #(
    parameter int bitwidth    = 32,
    parameter int nrOfEntries = 512
) (
    input  logic                           clock,
    input  logic [$clog2(nrOfEntries)-1:0] addressA,
    input  logic                           writeEnableA,
    input  logic [bitwidth-1:0]            dataInA,
    output logic [bitwidth-1:0]            dataOutA,
    input  logic [$clog2(nrOfEntries)-1:0] addressB,
    input  logic                           writeEnableB,
    input  logic [bitwidth-1:0]            dataInB,
    output logic [bitwidth-1:0]            dataOutB
);

    logic [bitwidth-1:0] mem_q [nrOfEntries];
    logic [bitwidth-1:0] rdata_a_q;
    logic [bitwidth-1:0] rdata_b_q;

    always_ff @(posedge clock) begin
        if (writeEnableA) begin
            mem_q[addressA] <= dataInA;
        end
        if (writeEnableB) begin
            mem_q[addressB] <= dataInB;
        end
        rdata_a_q <= mem_q[addressA];
        rdata_b_q <= mem_q[addressB];
    end

    assign dataOutA = rdata_a_q;
    assign dataOutB = rdata_b_q;

endmodule

// File: rtl/ram_dma_ci_engine.sv
// rtl/ram_dma_ci_engine.sv - CI scratchpad SSRAM with bus-master burst DMA
// Ports: clock/reset; CI side start, ciN, valueA, valueB -> done, result;
//        bus master side requestTransaction/transactionGranted, *Out address,
//        data and control, *In read data, stall, end and error from the slave.
module ram_dma_ci_engine #(
    parameter logic [7:0] customId = 8'h00,
    parameter int         ramDepth = 512,
    parameter int         maxBurst = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result,
    output logic        requestTransaction,
    input  logic        transactionGranted,
    output logic        beginTransactionOut,
    output logic [31:0] addressDataOut,
    output logic [7:0]  burstSizeOut,
    output logic        readNotWriteOut,
    output logic [3:0]  byteEnablesOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    input  logic        busyIn,
    input  logic        dataValidIn,
    input  logic [31:0] addressDataIn,
    input  logic        endTransactionIn,
    input  logic        busErrorIn
);
    import ram_dma_ci_pkg::*;

    localparam int ADDR_W = $clog2(ramDepth);

    dma_state_e         state_q, state_d;
    logic               dir_q, dir_d;            // 1 = SSRAM -> bus
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [BLOCK_W-1:0] remaining_q, remaining_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               error_q, error_d;
    logic               rd_pend_q, rd_pend_d;
    logic [31:0]        bus_start_q, bus_start_d;
    logic [ADDR_W-1:0]  mem_start_q, mem_start_d;
    logic [BLOCK_W-1:0] block_q, block_d;
    logic [BURST_W-1:0] burst_q, burst_d;

    logic               ci_hit, ci_write, busy, ci_done;
    logic [2:0]         ci_sel;
    logic [31:0]        ci_result, status;
    logic [10:0]        len_min;
    logic [LEN_W-1:0]   len_calc;
    logic [ADDR_W-1:0]  ram_b_addr;
    logic               ram_b_we, ram_a_we;
    logic [31:0]        ram_a_rdata, ram_b_rdata;
    logic               unused_valuea;

    assign ci_hit   = start && (ciN == customId);
    assign ci_sel   = valueA[12:10];
    assign ci_write = valueA[9];
    assign busy     = (state_q != ST_IDLE);
    assign ram_a_we = ci_hit && (ci_sel == SEL_BYPASS) && ci_write;
    assign unused_valuea = ^valueA[31:13];

    // Burst length: min(remaining, burst+1, maxBurst), never 0 while busy.
    always_comb begin
        len_min = 11'(remaining_q);
        if ((11'(burst_q) + 11'd1) < len_min) begin
            len_min = 11'(burst_q) + 11'd1;
        end
        if (11'(maxBurst) < len_min) begin
            len_min = 11'(maxBurst);
        end
        len_calc = LEN_W'(len_min);
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        bus_addr_d  = bus_addr_q;
        mem_addr_d  = mem_addr_q;
        remaining_d = remaining_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        error_d     = error_q;
        rd_pend_d   = 1'b0;
        bus_start_d = bus_start_q;
        mem_start_d = mem_start_q;
        block_d     = block_q;
        burst_d     = burst_q;

        requestTransaction  = 1'b0;
        beginTransactionOut = 1'b0;
        addressDataOut      = 32'd0;
        burstSizeOut        = 8'd0;
        readNotWriteOut     = 1'b0;
        byteEnablesOut      = 4'h0;
        dataValidOut        = 1'b0;
        endTransactionOut   = 1'b0;
        ram_b_we            = 1'b0;

        status             = 32'd0;
        status[STAT_BUSY]  = busy;
        status[STAT_ERROR] = error_q;

        ci_done   = 1'b0;
        ci_result = 32'd0;

        // CI decode and register file
        if (ci_hit) begin
            case (ci_sel)
                SEL_BYPASS: begin
                    rd_pend_d = !ci_write;
                    ci_done   = ci_write;
                end
                SEL_BUS_ADDR: begin
                    ci_done = 1'b1;
                    if (!ci_write) ci_result = bus_start_q;
                    else if (!busy) bus_start_d = valueB;
                end
                SEL_MEM_ADDR: begin
                    ci_done = 1'b1;
                    if (!ci_write) ci_result = 32'(mem_start_q);
                    else if (!busy) mem_start_d = valueB[ADDR_W-1:0];
                end
                SEL_BLOCK: begin
                    ci_done = 1'b1;
                    if (!ci_write) ci_result = 32'(block_q);
                    else if (!busy) block_d = valueB[BLOCK_W-1:0];
                end
                SEL_BURST: begin
                    ci_done = 1'b1;
                    if (!ci_write) begin
                        ci_result = 32'(burst_q);
                    end else if (!busy) begin
                        if (valueB[BURST_W-1:0] > BURST_W'(maxBurst - 1)) begin
                            burst_d = BURST_W'(maxBurst - 1);
                        end else begin
                            burst_d = valueB[BURST_W-1:0];
                        end
                    end
                end
                SEL_CTRL: begin
                    ci_done = 1'b1;
                    if (!ci_write) begin
                        ci_result = status;
                    end else if (!busy && (valueB[CTRL_RD_BUS] || valueB[CTRL_WR_BUS])) begin
                        error_d = 1'b0;
                        if (block_q != '0) begin
                            state_d     = ST_REQ;
                            dir_d       = !valueB[CTRL_RD_BUS];
                            bus_addr_d  = bus_start_q;
                            mem_addr_d  = mem_start_q;
                            remaining_d = block_q;
                        end
                    end
                end
                default: ci_done = 1'b1;
            endcase
        end

        // DMA engine
        case (state_q)
            ST_IDLE: ;
            ST_REQ: begin
                requestTransaction = 1'b1;
                if (transactionGranted) begin
                    len_d   = len_calc;
                    state_d = ST_BEGIN;
                end
            end
            ST_BEGIN: begin
                beginTransactionOut = 1'b1;
                addressDataOut      = bus_addr_q;
                burstSizeOut        = 8'(len_q - LEN_W'(1));
                readNotWriteOut     = !dir_q;
                byteEnablesOut      = 4'hF;
                cnt_d               = '0;
                state_d             = dir_q ? ST_WR_DATA : ST_RD_DATA;
            end
            ST_RD_DATA: begin
                // beats past the programmed length are dropped
                if (dataValidIn && (cnt_q != len_q)) begin
                    ram_b_we   = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    cnt_d      = cnt_q + LEN_W'(1);
                end
                if (endTransactionIn) begin
                    state_d = ST_NEXT;
                end
            end
            ST_WR_DATA: begin
                if (cnt_q == len_q) begin
                    endTransactionOut = 1'b1;
                    state_d           = ST_NEXT;
                end else begin
                    dataValidOut   = 1'b1;
                    addressDataOut = ram_b_rdata;
                    if (!busyIn) begin
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                        cnt_d      = cnt_q + LEN_W'(1);
                    end
                end
            end
            ST_NEXT: begin
                bus_addr_d  = bus_addr_q + {21'd0, len_q, 2'b00};
                remaining_d = remaining_q - BLOCK_W'(len_q);
                state_d     = (remaining_q != BLOCK_W'(len_q)) ? ST_REQ : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (busy && busErrorIn) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
        end

        // Writes use the current address; reads prefetch the next one so
        // the word for the following write beat is ready a cycle early.
        ram_b_addr = ram_b_we ? mem_addr_q : mem_addr_d;

        done   = !reset && (ci_done || rd_pend_q);
        result = !done ? 32'd0 : (rd_pend_q ? ram_a_rdata : ci_result);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            bus_addr_q  <= '0;
            mem_addr_q  <= '0;
            remaining_q <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            error_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            bus_start_q <= '0;
            mem_start_q <= '0;
            block_q     <= '0;
            burst_q     <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            bus_addr_q  <= bus_addr_d;
            mem_addr_q  <= mem_addr_d;
            remaining_q <= remaining_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            error_q     <= error_d;
            rd_pend_q   <= rd_pend_d;
            bus_start_q <= bus_start_d;
            mem_start_q <= mem_start_d;
            block_q     <= block_d;
            burst_q     <= burst_d;
        end
    end

    dual_port_ssram #(
        .bitwidth    (32),
        .nrOfEntries (ramDepth)
    ) u_ssram (
        .clock        (clock),
        .addressA     (valueA[ADDR_W-1:0]),
        .writeEnableA (ram_a_we),
        .dataInA      (valueB),
        .dataOutA     (ram_a_rdata),
        .addressB     (ram_b_addr),
        .writeEnableB (ram_b_we),
        .dataInB      (addressDataIn),
        .dataOutB     (ram_b_rdata)
    );

endmodule

// File: tb/tb_ram_dma_ci_engine.sv
// tb/tb_ram_dma_ci_engine.sv - directed self-checking bench for ram_dma_ci_engine
module tb_ram_dma_ci_engine;
    import ram_dma_ci_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  ciN = 8'h00;
    logic [31:0] valueA = '0, valueB = '0;
    logic        done;
    logic [31:0] result;
    logic        requestTransaction, beginTransactionOut, readNotWriteOut;
    logic        dataValidOut, endTransactionOut;
    logic [31:0] addressDataOut;
    logic [7:0]  burstSizeOut;
    logic [3:0]  byteEnablesOut;
    logic        transactionGranted = 1'b0, busyIn = 1'b0, dataValidIn = 1'b0;
    logic        endTransactionIn = 1'b0, busErrorIn = 1'b0;
    logic [31:0] addressDataIn = '0;
    logic [48:0] bus_outs;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign bus_outs = {requestTransaction, beginTransactionOut, addressDataOut, burstSizeOut,
                       readNotWriteOut, byteEnablesOut, dataValidOut, endTransactionOut};

    ram_dma_ci_engine dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .ciN                 (ciN),
        .valueA              (valueA),
        .valueB              (valueB),
        .done                (done),
        .result              (result),
        .requestTransaction  (requestTransaction),
        .transactionGranted  (transactionGranted),
        .beginTransactionOut (beginTransactionOut),
        .addressDataOut      (addressDataOut),
        .burstSizeOut        (burstSizeOut),
        .readNotWriteOut     (readNotWriteOut),
        .byteEnablesOut      (byteEnablesOut),
        .dataValidOut        (dataValidOut),
        .endTransactionOut   (endTransactionOut),
        .busyIn              (busyIn),
        .dataValidIn         (dataValidIn),
        .addressDataIn       (addressDataIn),
        .endTransactionIn    (endTransactionIn),
        .busErrorIn          (busErrorIn)
    );

    // One CI strobe cycle; returns done/result in that cycle and the next.
    task automatic ci_op(input logic [2:0] sel, input logic wr, input logic [8:0] addr,
                         input logic [31:0] data, output logic d0, output logic [31:0] r0,
                         output logic d1, output logic [31:0] r1);
        @(negedge clock);
        start  = 1'b1;
        valueA = {19'd0, sel, wr, addr};
        valueB = data;
        #1;
        d0 = done;
        r0 = result;
        @(negedge clock);
        start  = 1'b0;
        valueA = '0;
        valueB = '0;
        #1;
        d1 = done;
        r1 = result;
    endtask

    // Waits for a request, grants it, samples the address phase.
    task automatic bus_grant(output logic ok, output logic [31:0] a, output logic [7:0] bs,
                             output logic rnw, output logic [3:0] be);
        ok = 1'b0;
        a = '0; bs = '0; rnw = 1'b0; be = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            #1;
            if (requestTransaction) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            transactionGranted = 1'b1;
            @(negedge clock);
            transactionGranted = 1'b0;
            #1;
            ok  = beginTransactionOut;
            a   = addressDataOut;
            bs  = burstSizeOut;
            rnw = readNotWriteOut;
            be  = byteEnablesOut;
        end
    endtask

    task automatic bus_read_beats(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            dataValidIn      = 1'b1;
            addressDataIn    = base + 32'(i);
            endTransactionIn = (i == n - 1);
        end
        @(negedge clock);
        dataValidIn      = 1'b0;
        endTransactionIn = 1'b0;
        addressDataIn    = '0;
    endtask

    task automatic test_reset();
        logic d0, d1;
        logic [31:0] r0, r1;
        @(negedge clock);
        #1;
        checks++;
        if (bus_outs !== '0 || done !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_outputs got bus=%h done=%b result=%h want 0", bus_outs, done, result);
        end
        reset = 1'b0;
        ci_op(SEL_CTRL, 1'b0, 9'd0, 32'd0, d0, r0, d1, r1);
        checks++;
        if (d0 !== 1'b1 || r0 !== 32'd0) begin
            errors++;
            $display("FAIL reset_status got done=%b status=%h want 1/0", d0, r0);
        end
    endtask

    task automatic test_bypass();
        logic d0, d1;
        logic [31:0] r0, r1;
        ci_op(SEL_BYPASS, 1'b1, 9'd5, 32'hDEADBEEF, d0, r0, d1, r1);
        checks++;
        if (d0 !== 1'b1 || d1 !== 1'b0) begin
            errors++;
            $display("FAIL bypass_write_done got %b%b want 10", d0, d1);
        end
        ci_op(SEL_BYPASS, 1'b0, 9'd5, 32'd0, d0, r0, d1, r1);
        checks++;
        if (d0 !== 1'b0 || r0 !== 32'd0 || d1 !== 1'b1 || r1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_read got done=%b%b result=%h/%h want 01 0/deadbeef", d0, d1, r0, r1);
        end
    endtask

    task automatic test_regs();
        logic d0, d1;
        logic [31:0] r0, r1;
        logic [2:0]  sels [4] = '{SEL_BUS_ADDR, SEL_BLOCK, SEL_BURST, SEL_MEM_ADDR};
        logic [31:0] vals [4] = '{32'h0000_4000, 32'd20, 32'd7, 32'd0};
        for (int i = 0; i < 4; i++) begin
            ci_op(sels[i], 1'b1, 9'd0, vals[i], d0, r0, d1, r1);
        end
        for (int i = 0; i < 4; i++) begin
            ci_op(sels[i], 1'b0, 9'd0, 32'd0, d0, r0, d1, r1);
            checks++;
            if (d0 !== 1'b1 || r0 !== vals[i]) begin
                errors++;
                $display("FAIL reg_readback sel=%0d got done=%b val=%h want 1/%h", sels[i], d0, r0, vals[i]);
            end
        end
        ci_op(3'd6, 1'b0, 9'd0, 32'd0, d0, r0, d1, r1);
        checks++;
        if (d0 !== 1'b1 || r0 !== 32'd0) begin
            errors++;
            $display("FAIL reserved_sel got done=%b result=%h want 1/0", d0, r0);
        end
        ci_op(SEL_BURST, 1'b1, 9'd0, 32'd200, d0, r0, d1, r1);
        ci_op(SEL_BURST, 1'b0, 9'd0, 32'd0, d0, r0, d1, r1);
        checks++;
        if (r0 !== 32'd15) begin
            errors++;
            $display("FAIL burst_clamp got %0d want 15", r0);
        end
        ci_op(SEL_BURST, 1'b1, 9'd0, 32'd7, d0, r0, d1, r1);
        ci_op(SEL_BLOCK, 1'b1, 9'd0, 32'd0, d0, r0, d1, r1);
        ci_op(SEL_CTRL, 1'b1, 9'd0, 32'd1, d0, r0, d1, r1);
        ci_op(SEL_CTRL, 1'b0, 9'd0, 32'd0, d0, r0, d1, r1);
        checks++;
        if (r0 !== 32'd0 || requestTransaction !== 1'b0) begin
            errors++;
            $display("FAIL zero_block_start got status=%h req=%b want 0/0", r0, requestTransaction);
        end
        ci_op(SEL_BLOCK, 1'b1, 9'd0, 32'd20, d0, r0, d1, r1);
    endtask

    task automatic test_bus_to_ssram();
        logic d0, d1, ok, rnw;
        logic [31:0] r0, r1, a;
        logic [7:0]  bs;
        logic [3:0]  be;
        int bad;
        ci_op(SEL_CTRL, 1'b1, 9'd0, 32'd1, d0, r0, d1, r1);
        ci_op(SEL_CTRL, 1'b0, 9'd0, 32'd0, d0, r0, d1, r1);
        checks++;
        if (r0 !== 32'd1) begin
            errors++;
            $display("FAIL rd_busy_status got %h want 1", r0);
        end
        ci_op(SEL_BUS_ADDR, 1'b1, 9'd0, 32'h0000_9999, d0, r0, d1, r1);
        for (int b = 0; b < 3; b++) begin
            bus_grant(ok, a, bs, rnw, be);
            checks++;
            if (ok !== 1'b1 || a !== 32'h4000 + 32'(b * 32) || bs !== ((b == 2) ? 8'd3 : 8'd7)
                || rnw !== 1'b1 || be !== 4'hF) begin
                errors++;
                $display("FAIL rd_burst%0d got ok=%b addr=%h len=%0d rnw=%b be=%h want 1/%h/%0d/1/f",
                         b, ok, a, bs, rnw, be, 32'h4000 + 32'(b * 32), (b == 2) ? 3 : 7);
            end
            bus_read_beats((b == 2) ? 4 : 8, 32'hA000_0000 + 32'(b * 8));
        end
        ci_op(SEL_CTRL, 1'b0, 9'd0, 32'd0, d0, r0, d1, r1);
        checks++;
        if (r0 !== 32'd0) begin
            errors++;
            $display("FAIL rd_idle_status got %h want 0", r0);
        end
        ci_op(SEL_BUS_ADDR, 1'b0, 9'd0, 32'd0, d0, r0, d1, r1);
        checks++;
        if (r0 !== 32'h4000) begin
            errors++;
            $display("FAIL write_while_busy got %h want 4000", r0);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            ci_op(SEL_BYPASS, 1'b0, 9'(i), 32'd0, d0, r0, d1, r1);
            checks++;
            if (r1 !== 32'hA000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL rd_ssram[%0d] got %h want %h", i, r1, 32'hA000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_ssram_to_bus();
        logic d0, d1, ok, rnw;
        logic [31:0] r0, r1, a;
        logic [7:0]  bs;
        logic [3:0]  be;
        logic [31:0] beats [8];
        int nb, ends;
        ci_op(SEL_BUS_ADDR, 1'b1, 9'd0, 32'h8000, d0, r0, d1, r1);
        ci_op(SEL_BLOCK, 1'b1, 9'd0, 32'd5, d0, r0, d1, r1);
        ci_op(SEL_BURST, 1'b1, 9'd0, 32'd15, d0, r0, d1, r1);
        ci_op(SEL_CTRL, 1'b1, 9'd0, 32'd2, d0, r0, d1, r1);
        bus_grant(ok, a, bs, rnw, be);
        checks++;
        if (ok !== 1'b1 || a !== 32'h8000 || bs !== 8'd4 || rnw !== 1'b0) begin
            errors++;
            $display("FAIL wr_begin got ok=%b addr=%h len=%0d rnw=%b want 1/8000/4/0", ok, a, bs, rnw);
        end
        nb = 0;
        ends = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            busyIn = (i % 2 == 0);
            #1;
            if (endTransactionOut) ends++;
            if (dataValidOut && !busyIn) begin
                if (nb < 8) beats[nb] = addressDataOut;
                nb++;
            end
        end
        busyIn = 1'b0;
        checks++;
        if (nb !== 5 || ends !== 1) begin
            errors++;
            $display("FAIL wr_beat_count got beats=%0d ends=%0d want 5/1", nb, ends);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (beats[k] !== 32'hA000_0000 + 32'(k)) begin
                errors++;
                $display("FAIL wr_beat[%0d] got %h want %h", k, beats[k], 32'hA000_0000 + 32'(k));
            end
        end
        ci_op(SEL_CTRL, 1'b0, 9'd0, 32'd0, d0, r0, d1, r1);
        checks++;
        if (r0 !== 32'd0) begin
            errors++;
            $display("FAIL wr_idle_status got %h want 0", r0);
        end
    endtask

    task automatic test_bus_error();
        logic d0, d1, ok, rnw;
        logic [31:0] r0, r1, a;
        logic [7:0]  bs;
        logic [3:0]  be;
        ci_op(SEL_BUS_ADDR, 1'b1, 9'd0, 32'h4000, d0, r0, d1, r1);
        ci_op(SEL_BLOCK, 1'b1, 9'd0, 32'd20, d0, r0, d1, r1);
        ci_op(SEL_BURST, 1'b1, 9'd0, 32'd7, d0, r0, d1, r1);
        ci_op(SEL_CTRL, 1'b1, 9'd0, 32'd1, d0, r0, d1, r1);
        bus_grant(ok, a, bs, rnw, be);
        bus_read_beats(8, 32'hE000_0000);
        bus_grant(ok, a, bs, rnw, be);
        checks++;
        if (ok !== 1'b1 || a !== 32'h4020) begin
            errors++;
            $display("FAIL err_second_burst got ok=%b addr=%h want 1/4020", ok, a);
        end
        @(negedge clock);
        dataValidIn   = 1'b1;
        addressDataIn = 32'hE000_0008;
        @(negedge clock);
        dataValidIn   = 1'b0;
        addressDataIn = '0;
        busErrorIn    = 1'b1;
        @(negedge clock);
        busErrorIn = 1'b0;
        #1;
        checks++;
        if (bus_outs !== '0) begin
            errors++;
            $display("FAIL err_bus_release got %h want 0", bus_outs);
        end
        ci_op(SEL_CTRL, 1'b0, 9'd0, 32'd0, d0, r0, d1, r1);
        checks++;
        if (r0 !== 32'd2) begin
            errors++;
            $display("FAIL err_status got %h want 2", r0);
        end
        ci_op(SEL_CTRL, 1'b1, 9'd0, 32'd1, d0, r0, d1, r1);
        ci_op(SEL_CTRL, 1'b0, 9'd0, 32'd0, d0, r0, d1, r1);
        checks++;
        if (r0 !== 32'd1) begin
            errors++;
            $display("FAIL err_cleared_by_start got %h want 1", r0);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic d0, d1, ok, rnw;
        logic [31:0] r0, r1, a;
        logic [7:0]  bs;
        logic [3:0]  be;
        bus_grant(ok, a, bs, rnw, be);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            dataValidIn   = 1'b1;
            addressDataIn = 32'hF000_0000 + 32'(i);
        end
        @(negedge clock);
        dataValidIn   = 1'b0;
        addressDataIn = '0;
        reset         = 1'b1;
        #1;
        checks++;
        if (bus_outs !== '0 || done !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got bus=%h done=%b result=%h want 0", bus_outs, done, result);
        end
        @(negedge clock);
        reset = 1'b0;
        ci_op(SEL_CTRL, 1'b0, 9'd0, 32'd0, d0, r0, d1, r1);
        checks++;
        if (r0 !== 32'd0) begin
            errors++;
            $display("FAIL midreset_status got %h want 0", r0);
        end
        ci_op(SEL_BUS_ADDR, 1'b0, 9'd0, 32'd0, d0, r0, d1, r1);
        checks++;
        if (r0 !== 32'd0) begin
            errors++;
            $display("FAIL midreset_regs got %h want 0", r0);
        end
    endtask

    task automatic test_wrap();
        logic d0, d1, ok, rnw;
        logic [31:0] r0, r1, a;
        logic [7:0]  bs;
        logic [3:0]  be;
        logic [8:0]  addrs [5] = '{9'd510, 9'd511, 9'd0, 9'd1, 9'd2};
        logic [31:0] exp   [5] = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002,
                                   32'hC000_0003, 32'hE000_0002};
        ci_op(SEL_BUS_ADDR, 1'b1, 9'd0, 32'h100, d0, r0, d1, r1);
        ci_op(SEL_MEM_ADDR, 1'b1, 9'd0, 32'd510, d0, r0, d1, r1);
        ci_op(SEL_BLOCK, 1'b1, 9'd0, 32'd4, d0, r0, d1, r1);
        ci_op(SEL_BURST, 1'b1, 9'd0, 32'd7, d0, r0, d1, r1);
        ci_op(SEL_CTRL, 1'b1, 9'd0, 32'd3, d0, r0, d1, r1);
        bus_grant(ok, a, bs, rnw, be);
        checks++;
        if (ok !== 1'b1 || a !== 32'h100 || bs !== 8'd3 || rnw !== 1'b1) begin
            errors++;
            $display("FAIL wrap_begin got ok=%b addr=%h len=%0d rnw=%b want 1/100/3/1", ok, a, bs, rnw);
        end
        bus_read_beats(5, 32'hC000_0000);
        for (int i = 0; i < 5; i++) begin
            ci_op(SEL_BYPASS, 1'b0, addrs[i], 32'd0, d0, r0, d1, r1);
            checks++;
            if (r1 !== exp[i]) begin
                errors++;
                $display("FAIL wrap_ssram[%0d] got %h want %h", addrs[i], r1, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_regs();
        test_bus_to_ssram();
        test_ssram_to_bus();
        test_bus_error();
        test_reset_mid_burst();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

endmodule
